// File: rtl/timer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a level
// interrupt, exposed as a word-addressed bus device.
module timer #(
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        timer_irq_o
);

    localparam logic [9:0] IdxMtimeLo = 10'd0;
    localparam logic [9:0] IdxMtimeHi = 10'd1;
    localparam logic [9:0] IdxCmpLo   = 10'd2;
    localparam logic [9:0] IdxCmpHi   = 10'd3;
    localparam logic [9:0] IdxCtrl    = 10'd4;
    localparam logic [9:0] IdxPre     = 10'd5;

    logic [63:0]              mtime_q, mtime_d;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic                     en_q, en_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    logic [PrescaleWidth-1:0] pcnt_q, pcnt_d;
    logic                     rvalid_q, rvalid_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     irq_q, irq_d;

    logic [9:0]  widx;
    logic        wr, rd;
    logic        sel_mlo, sel_mhi, sel_clo, sel_chi, sel_ctrl, sel_pre;
    logic        ctl_wr, hit, tick;
    logic [31:0] pre_wr;
    logic        unused_addr;

    assign widx        = device_addr_i[11:2];
    assign unused_addr = ^{device_addr_i[31:12], device_addr_i[1:0]};

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    always_comb begin
        wr       = device_req_i & device_we_i;
        rd       = device_req_i & ~device_we_i;
        sel_mlo  = widx == IdxMtimeLo;
        sel_mhi  = widx == IdxMtimeHi;
        sel_clo  = widx == IdxCmpLo;
        sel_chi  = widx == IdxCmpHi;
        sel_ctrl = widx == IdxCtrl;
        sel_pre  = widx == IdxPre;
        // Reprogramming the tick source restarts the prescale phase.
        ctl_wr   = wr & (sel_ctrl | sel_pre);
        hit      = en_q & (pcnt_q == prescale_q);
        tick     = hit & ~ctl_wr;
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (ctl_wr) begin
            pcnt_d = '0;
        end else if (en_q) begin
            pcnt_d = hit ? '0 : pcnt_q + PrescaleWidth'(1);
        end
    end

    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        en_d       = en_q;
        prescale_d = prescale_q;
        pre_wr     = merge_bytes(32'(prescale_q), device_wdata_i, device_be_i);
        if (wr) begin
            unique case (1'b1)
                sel_mlo: mtime_d = {mtime_q[63:32],
                    merge_bytes(mtime_q[31:0], device_wdata_i, device_be_i)};
                sel_mhi: mtime_d = {
                    merge_bytes(mtime_q[63:32], device_wdata_i, device_be_i),
                    tick ? mtime_q[31:0] + 32'd1 : mtime_q[31:0]};
                sel_clo: mtimecmp_d[31:0] =
                    merge_bytes(mtimecmp_q[31:0], device_wdata_i, device_be_i);
                sel_chi: mtimecmp_d[63:32] =
                    merge_bytes(mtimecmp_q[63:32], device_wdata_i, device_be_i);
                sel_ctrl: en_d = device_be_i[0] ? device_wdata_i[0] : en_q;
                sel_pre: prescale_d = pre_wr[PrescaleWidth-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rvalid_d = device_req_i;
        irq_d    = mtime_q >= mtimecmp_q;
        rdata_d  = '0;
        if (rd) begin
            unique case (1'b1)
                sel_mlo:  rdata_d = mtime_q[31:0];
                sel_mhi:  rdata_d = mtime_q[63:32];
                sel_clo:  rdata_d = mtimecmp_q[31:0];
                sel_chi:  rdata_d = mtimecmp_q[63:32];
                sel_ctrl: rdata_d = {31'd0, en_q};
                sel_pre:  rdata_d = 32'(prescale_q);
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            en_q       <= 1'b0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            en_q       <= en_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign timer_irq_o     = irq_q;

endmodule
